map_loader: RTL and testbench

MAP_LOADER -- requirements
Module: map_loader

---
 rtl/map_pkg.sv | 29 ++
 rtl/map_loader_if.sv | 13 +
 rtl/map_ram.sv | 39 +++
 rtl/map_loader.sv | 141 ++++++++++++++
 tb/tb_map_loader.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/map_pkg.sv
// Shared definitions for the map loader: cell codes, headings, default
// map geometry and the loader FSM state type.
package map_pkg;

    typedef logic [3:0] nibble_t;

    localparam logic [2:0] CELL_FREE   = 3'd0;
    localparam logic [2:0] CELL_WALL   = 3'd1;
    localparam logic [2:0] CELL_BLACK  = 3'd2;
    localparam logic [2:0] CELL_LIGHT  = 3'd3;
    localparam logic [2:0] CELL_MEDIUM = 3'd4;
    localparam logic [2:0] CELL_HEAVY  = 3'd5;

    localparam nibble_t HEAD_N = 4'd0;
    localparam nibble_t HEAD_W = 4'd1;
    localparam nibble_t HEAD_S = 4'd2;
    localparam nibble_t HEAD_E = 4'd3;

    localparam int DEF_COLS = 10;
    localparam int DEF_ROWS = 20;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_CELLS,
        S_COMMIT
    } state_t;

endpackage

// File: rtl/map_loader_if.sv
// Nibble stream handshake into the map loader, with a frame-start strobe.
interface map_loader_if;
    import map_pkg::*;

    logic    sof;
    logic    in_valid;
    nibble_t in_data;
    logic    in_ready;

    modport master (output sof, output in_valid, output in_data, input in_ready);
    modport slave  (input sof, input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/map_ram.sv
// Map cell storage: one write port, one registered read port that returns
// WALL for out-of-range coordinates; asynchronously cleared by reset.
module map_ram
    import map_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           we,
    input  logic [$clog2(COLS*ROWS)-1:0]   waddr,
    input  logic [2:0]                     wdata,
    input  logic                           rd_ok,
    input  logic [$clog2(COLS*ROWS)-1:0]   raddr,
    output logic [2:0]                     rd_cell
);

    localparam int unsigned DEPTH = COLS * ROWS;
    localparam int          AW    = $clog2(COLS*ROWS);

    logic [2:0] mem [DEPTH];

    // Read and write share the edge, so a same-cell read returns the old value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[AW'(i)] <= CELL_FREE;
            end
            rd_cell <= '0;
        end else begin
            if (we) begin
                mem[waddr] <= wdata;
            end
            rd_cell <= rd_ok ? mem[raddr] : CELL_WALL;
        end
    end

endmodule

// File: rtl/map_loader.sv
// Loads a robot map frame (3 header nibbles + COLS*ROWS cell nibbles) into
// map storage and commits the robot pose atomically at end of frame.
module map_loader
    import map_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS
) (
    input  logic             clk,
    input  logic             rst,
    map_loader_if.slave      bus,
    input  logic [3:0]       rd_x,
    input  logic [4:0]       rd_y,
    output logic [2:0]       rd_cell,
    output logic [3:0]       xr,
    output logic [3:0]       yr,
    output logic [3:0]       dr,
    output logic             busy,
    output logic             frame_done,
    output logic             err
);

    localparam int AW = $clog2(COLS*ROWS);

    state_t        state;
    logic [1:0]    hcnt;
    nibble_t       sx, sy, sdir;
    logic          hdr_bad;
    logic [3:0]    cx;
    logic [4:0]    cy;
    logic          ready_q;

    logic          xfer;
    logic          last_cell;
    logic          cell_bad;
    logic          hdr_bad_now;
    logic          we;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic          rd_ok;

    assign bus.in_ready = ready_q;

    // A nibble presented on the sof cycle is never consumed.
    assign xfer        = bus.in_valid && ready_q && !bus.sof;
    assign last_cell   = (int'(cx) == COLS-1) && (int'(cy) == ROWS-1);
    assign cell_bad    = bus.in_data > {1'b0, CELL_HEAVY};
    assign hdr_bad_now = (int'(sx) >= COLS) || (int'(sy) >= ROWS) || (bus.in_data > HEAD_E);
    assign we          = (state == S_CELLS) && xfer;
    assign waddr       = AW'(cy) * AW'(COLS) + AW'(cx);
    assign raddr       = AW'(rd_y) * AW'(COLS) + AW'(rd_x);
    assign rd_ok       = (int'(rd_x) < COLS) && (int'(rd_y) < ROWS);

    map_ram #(
        .COLS(COLS),
        .ROWS(ROWS)
    ) u_map_ram (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (cell_bad ? CELL_FREE : bus.in_data[2:0]),
        .rd_ok  (rd_ok),
        .raddr  (raddr),
        .rd_cell(rd_cell)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            hcnt       <= '0;
            sx         <= '0;
            sy         <= '0;
            sdir       <= '0;
            hdr_bad    <= 1'b0;
            cx         <= '0;
            cy         <= '0;
            ready_q    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            xr         <= '0;
            yr         <= '0;
            dr         <= '0;
        end else begin
            frame_done <= 1'b0;
            if (bus.sof) begin
                state   <= S_HDR;
                hcnt    <= '0;
                cx      <= '0;
                cy      <= '0;
                hdr_bad <= 1'b0;
                err     <= 1'b0;
                ready_q <= 1'b1;
                busy    <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: ;
                    S_HDR: if (xfer) begin
                        hcnt <= hcnt + 2'd1;
                        case (hcnt)
                            2'd0:    sx <= bus.in_data;
                            2'd1:    sy <= bus.in_data;
                            default: begin
                                sdir    <= bus.in_data;
                                hdr_bad <= hdr_bad_now;
                                if (hdr_bad_now) err <= 1'b1;
                                state   <= S_CELLS;
                            end
                        endcase
                    end
                    S_CELLS: if (xfer) begin
                        if (cell_bad) err <= 1'b1;
                        if (last_cell) begin
                            // Pose and frame_done become visible together in COMMIT.
                            state      <= S_COMMIT;
                            ready_q    <= 1'b0;
                            frame_done <= 1'b1;
                            if (!hdr_bad) begin
                                xr <= sx;
                                yr <= sy;
                                dr <= sdir;
                            end
                        end else if (int'(cx) == COLS-1) begin
                            cx <= '0;
                            cy <= cy + 5'd1;
                        end else begin
                            cx <= cx + 4'd1;
                        end
                    end
                    S_COMMIT: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_map_loader.sv
// Directed bench for map_loader: full frames, back-pressure, header/cell
// errors, mid-frame restart and mid-frame reset.
module tb_map_loader;

    logic       clk;
    logic       rst;
    logic [3:0] rd_x;
    logic [4:0] rd_y;
    logic [2:0] rd_cell;
    logic [3:0] xr, yr, dr;
    logic       busy, frame_done, err;

    int vectors;
    int miscompares;
    int done_cnt;

    logic [3:0] fr [203];

    map_loader_if bus ();

    map_loader #(
        .COLS(10),
        .ROWS(20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .rd_x      (rd_x),
        .rd_y      (rd_y),
        .rd_cell   (rd_cell),
        .xr        (xr),
        .yr        (yr),
        .dr        (dr),
        .busy      (busy),
        .frame_done(frame_done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

    // fill < 0 selects the (x+y) mod 6 pattern
    task automatic build(input int hx, input int hy, input int hd, input int fill);
        fr[0] = 4'(hx);
        fr[1] = 4'(hy);
        fr[2] = 4'(hd);
        for (int y = 0; y < 20; y++)
            for (int x = 0; x < 10; x++)
                fr[3 + y*10 + x] = (fill < 0) ? 4'((x + y) % 6) : 4'(fill);
    endtask

    task automatic start_frame();
        bus.sof      = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 4'hF;
        @(posedge clk); #1;
        bus.sof      = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic stream(input bit bp, input int n, output int cycles);
        int k;
        k = 0;
        cycles = 0;
        while (k < n && cycles < 5000) begin
            bus.in_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_data  = fr[k];
            if (bus.in_valid && bus.in_ready) k++;
            @(posedge clk); #1;
            cycles++;
        end
        bus.in_valid = 1'b0;
        vectors++;
        if (k !== n) begin
            miscompares++;
            $display("FAIL stream_budget: transfers %0d, required %0d", k, n);
        end
    endtask

    task automatic rd(input logic [3:0] x, input logic [4:0] y, output logic [2:0] c);
        rd_x = x;
        rd_y = y;
        @(posedge clk); #1;
        c = rd_cell;
    endtask

    task automatic check_pattern_reads(input string tag);
        logic [3:0] xs [7] = '{4, 0, 5, 9, 10, 0, 15};
        logic [4:0] ys [7] = '{5, 0, 0, 19, 0, 20, 31};
        logic [2:0] ex [7] = '{3, 0, 5, 4, 1, 1, 1};
        logic [2:0] c;
        for (int i = 0; i < 7; i++) begin
            rd(xs[i], ys[i], c);
            vectors++;
            if (c !== ex[i]) begin
                miscompares++;
                $display("FAIL %s_rd(%0d,%0d): got %0d, required %0d", tag, xs[i], ys[i], c, ex[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({bus.in_ready, busy, frame_done, err} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b, required 0000", {bus.in_ready, busy, frame_done, err});
        end
        vectors++;
        if ({xr, yr, dr} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_pose: got %h, required 000", {xr, yr, dr});
        end
        vectors++;
        if (rd_cell !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_rd_cell: got %0d, required 0", rd_cell);
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_full_frame();
        int cyc, d0;
        build(3, 7, 2, -1);
        d0 = done_cnt;
        start_frame();
        vectors++;
        if ({bus.in_ready, busy} !== 2'b11) begin
            miscompares++;
            $display("FAIL full_hdr_flags: got %b, required 11", {bus.in_ready, busy});
        end
        stream(1'b0, 203, cyc);
        vectors++;
        if (cyc !== 203) begin
            miscompares++;
            $display("FAIL full_latency: got %0d cycles, required 203", cyc);
        end
        vectors++;
        if ({frame_done, busy, bus.in_ready} !== 3'b110) begin
            miscompares++;
            $display("FAIL full_commit_flags: got %b, required 110", {frame_done, busy, bus.in_ready});
        end
        vectors++;
        if ({xr, yr, dr, err} !== 13'h0372 << 1) begin
            miscompares++;
            $display("FAIL full_pose_err: got %h/%b, required 372/0", {xr, yr, dr}, err);
        end
        @(posedge clk); #1;
        vectors++;
        if ({frame_done, busy, done_cnt - d0} !== {2'b00, 32'd1}) begin
            miscompares++;
            $display("FAIL full_idle: done=%b busy=%b pulses=%0d, required 0 0 1", frame_done, busy, done_cnt - d0);
        end
        check_pattern_reads("full");
    endtask

    task automatic test_back_pressure();
        int cyc, d0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        build(3, 7, 2, -1);
        d0 = done_cnt;
        start_frame();
        stream(1'b1, 203, cyc);
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({xr, yr, dr, err, done_cnt - d0} !== {12'h372, 1'b0, 32'd1}) begin
            miscompares++;
            $display("FAIL bp_commit: pose=%h err=%b pulses=%0d, required 372 0 1", {xr, yr, dr}, err, done_cnt - d0);
        end
        check_pattern_reads("bp");
    endtask

    task automatic test_bad_header();
        int cyc, d0;
        logic [2:0] c;
        build(10, 0, 0, 2);
        d0 = done_cnt;
        start_frame();
        stream(1'b0, 203, cyc);
        vectors++;
        if ({frame_done, err} !== 2'b11) begin
            miscompares++;
            $display("FAIL badhdr_flags: done=%b err=%b, required 1 1", frame_done, err);
        end
        vectors++;
        if ({xr, yr, dr} !== 12'h372) begin
            miscompares++;
            $display("FAIL badhdr_pose: got %h, required 372", {xr, yr, dr});
        end
        rd(4'd4, 5'd5, c);
        vectors++;
        if (c !== 3'd2 || done_cnt - d0 !== 1) begin
            miscompares++;
            $display("FAIL badhdr_cells: rd(4,5)=%0d pulses=%0d, required 2 1", c, done_cnt - d0);
        end
    endtask

    task automatic test_bad_cell();
        int cyc;
        logic [2:0] c;
        build(2, 4, 3, -1);
        fr[3] = 4'd9;
        start_frame();
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL badcell_sof_clears_err: got %b, required 0", err);
        end
        stream(1'b0, 203, cyc);
        @(posedge clk); #1;
        vectors++;
        if ({err, xr, yr, dr} !== {1'b1, 12'h243}) begin
            miscompares++;
            $display("FAIL badcell_err_pose: err=%b pose=%h, required 1 243", err, {xr, yr, dr});
        end
        rd(4'd0, 5'd0, c);
        vectors++;
        if (c !== 3'd0) begin
            miscompares++;
            $display("FAIL badcell_rd00: got %0d, required 0", c);
        end
        rd(4'd4, 5'd5, c);
        vectors++;
        if (c !== 3'd3) begin
            miscompares++;
            $display("FAIL badcell_rd45: got %0d, required 3", c);
        end
    endtask

    task automatic test_restart();
        int cyc, d0;
        logic [2:0] c;
        d0 = done_cnt;
        build(5, 5, 0, 5);
        start_frame();
        stream(1'b0, 53, cyc);
        build(1, 1, 1, -1);
        start_frame();
        vectors++;
        if ({err, busy, bus.in_ready, xr, yr, dr} !== {3'b011, 12'h243}) begin
            miscompares++;
            $display("FAIL restart_sof: err=%b busy=%b rdy=%b pose=%h, required 0 1 1 243",
                     err, busy, bus.in_ready, {xr, yr, dr});
        end
        stream(1'b0, 203, cyc);
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({xr, yr, dr, err, done_cnt - d0} !== {12'h111, 1'b0, 32'd1}) begin
            miscompares++;
            $display("FAIL restart_commit: pose=%h err=%b pulses=%0d, required 111 0 1", {xr, yr, dr}, err, done_cnt - d0);
        end
        rd(4'd4, 5'd5, c);
        vectors++;
        if (c !== 3'd3) begin
            miscompares++;
            $display("FAIL restart_rd45: got %0d, required 3", c);
        end
    endtask

    task automatic test_reset_mid_frame();
        int cyc;
        logic [2:0] c;
        build(6, 6, 1, 5);
        start_frame();
        stream(1'b0, 83, cyc);
        rst = 1'b0;
        #1;
        vectors++;
        if ({bus.in_ready, busy, frame_done, err, xr, yr, dr, rd_cell} !== 19'd0) begin
            miscompares++;
            $display("FAIL rstmid_outputs: rdy=%b busy=%b done=%b err=%b pose=%h cell=%0d, required all 0",
                     bus.in_ready, busy, frame_done, err, {xr, yr, dr}, rd_cell);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        rd(4'd4, 5'd5, c);
        vectors++;
        if (c !== 3'd0) begin
            miscompares++;
            $display("FAIL rstmid_rd45: got %0d, required 0", c);
        end
        rd(4'd10, 5'd3, c);
        vectors++;
        if (c !== 3'd1) begin
            miscompares++;
            $display("FAIL rstmid_rd_oob: got %0d, required 1", c);
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        done_cnt     = 0;
        rst          = 1'b0;
        bus.sof      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 4'h0;
        rd_x         = 4'd0;
        rd_y         = 5'd0;
        test_reset();
        test_full_frame();
        test_back_pressure();
        test_bad_header();
        test_bad_cell();
        test_restart();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
